// File: rtl/vga_pkg.sv
// Shared VGA constants and types used by the object-path layer muxes.
package vga_pkg;
  localparam int RGB_W = 8;
  localparam logic [7:0] BG_WHITE = 8'hFF;

  typedef logic [RGB_W-1:0] rgb_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: first requester at or after ptr,
// scanning upward and wrapping modulo NUM_CH.
module rr_priority_pick import vga_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int IDXW   = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDXW-1:0]   ptr,
  output logic              valid,
  output logic [IDXW-1:0]   idx
);

  int c;

  // Walk from the farthest candidate back to ptr so the nearest one is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (req[IDXW'(c)]) begin
        valid = 1'b1;
        idx   = IDXW'(c);
      end
    end
  end

endmodule

// File: rtl/sprite_layer_mux.sv
// Sprite layer compositor: registered winner RGB/request with fixed or per-frame
// rotating priority, plus sticky per-frame sprite collision masks.
module sprite_layer_mux import vga_pkg::*; #(
  parameter int               NUM_CH = 4,
  parameter int               RGB_W  = vga_pkg::RGB_W,
  parameter logic [RGB_W-1:0] BG_RGB = RGB_W'(BG_WHITE),
  localparam int              IDXW   = idx_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startOfFrame,
  input  logic                         rotateEn,
  input  logic [NUM_CH-1:0]            drawReq,
  input  logic [NUM_CH-1:0][RGB_W-1:0] rgbIn,
  output logic                         layerDrawingRequest,
  output logic [RGB_W-1:0]             layerRGB,
  output logic [IDXW-1:0]              winnerIdx,
  output logic [NUM_CH-1:0]            collisionMask,
  output logic [NUM_CH-1:0]            frameCollision
);

  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic              req_q, req_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic [IDXW-1:0]   win_q, win_d;
  logic [NUM_CH-1:0] cmask_q, cmask_d;
  logic [NUM_CH-1:0] fcoll_q, fcoll_d;

  logic              pick_valid;
  logic [IDXW-1:0]   pick_idx;
  logic [NUM_CH-1:0] overlap;

  rr_priority_pick #(
    .NUM_CH (NUM_CH),
    .IDXW   (IDXW)
  ) u_pick (
    .req   (drawReq),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    overlap = ($countones(drawReq) >= 2) ? drawReq : '0;

    req_d = pick_valid;
    rgb_d = pick_valid ? rgbIn[pick_idx] : BG_RGB;
    win_d = pick_valid ? pick_idx : '0;

    // Pointer change only shows up after the pulse; the pulse cycle uses the old value.
    ptr_d = ptr_q;
    if (!rotateEn) begin
      ptr_d = '0;
    end else if (startOfFrame) begin
      ptr_d = (ptr_q == IDXW'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
    end

    // The startOfFrame cycle already belongs to the new frame.
    if (startOfFrame) begin
      fcoll_d = cmask_q;
      cmask_d = overlap;
    end else begin
      fcoll_d = fcoll_q;
      cmask_d = cmask_q | overlap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      req_q   <= 1'b0;
      rgb_q   <= BG_RGB;
      win_q   <= '0;
      cmask_q <= '0;
      fcoll_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      rgb_q   <= rgb_d;
      win_q   <= win_d;
      cmask_q <= cmask_d;
      fcoll_q <= fcoll_d;
    end
  end

  assign layerDrawingRequest = req_q;
  assign layerRGB            = rgb_q;
  assign winnerIdx           = win_q;
  assign collisionMask       = cmask_q;
  assign frameCollision      = fcoll_q;

endmodule

// File: tb/tb_sprite_layer_mux.sv
// Bench for sprite_layer_mux: 4-, 3- and 1-channel builds driven in parallel
// and checked against a frame-level reference model.
module tb_sprite_layer_mux;

  logic            clk = 1'b0;
  logic            reset;
  logic            sof;
  logic            rot;
  logic [3:0]      req4;
  logic [3:0][7:0] rgb4;

  logic       r4, r3, r1;
  logic [7:0] c4, c3, c1;
  logic [1:0] w4, w3;
  logic [0:0] w1;
  logic [3:0] cm4, fc4;
  logic [2:0] cm3, fc3;
  logic [0:0] cm1, fc1;

  int checks = 0;
  int errors = 0;

  // reference model state, one slot per build
  int         nch [3] = '{4, 3, 1};
  int         ptr_m [3];
  logic [3:0] cm_m [3];
  logic [3:0] fc_m [3];
  logic       e_req [3];
  logic [7:0] e_rgb [3];
  int         e_win [3];

  always #5 clk = ~clk;

  sprite_layer_mux #(.NUM_CH(4)) u4 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .rotateEn(rot),
    .drawReq(req4), .rgbIn(rgb4),
    .layerDrawingRequest(r4), .layerRGB(c4), .winnerIdx(w4),
    .collisionMask(cm4), .frameCollision(fc4));

  sprite_layer_mux #(.NUM_CH(3)) u3 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .rotateEn(rot),
    .drawReq(req4[2:0]), .rgbIn(rgb4[2:0]),
    .layerDrawingRequest(r3), .layerRGB(c3), .winnerIdx(w3),
    .collisionMask(cm3), .frameCollision(fc3));

  sprite_layer_mux #(.NUM_CH(1)) u1 (
    .clk(clk), .reset(reset), .startOfFrame(sof), .rotateEn(rot),
    .drawReq(req4[0:0]), .rgbIn(rgb4[0:0]),
    .layerDrawingRequest(r1), .layerRGB(c1), .winnerIdx(w1),
    .collisionMask(cm1), .frameCollision(fc1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ptr_m[i] = 0; cm_m[i] = '0; fc_m[i] = '0;
      e_req[i] = 1'b0; e_rgb[i] = 8'hFF; e_win[i] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [3:0] rq, ov;
    int n, w, cnt;
    bit found;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      n  = nch[i];
      rq = req4 & 4'((1 << n) - 1);
      found = 0; w = 0;
      for (int k = 0; k < n; k++)
        if (!found && rq[(ptr_m[i] + k) % n]) begin found = 1; w = (ptr_m[i] + k) % n; end
      e_req[i] = found;
      e_rgb[i] = found ? rgb4[w] : 8'hFF;
      e_win[i] = found ? w : 0;
      cnt = 0;
      for (int b = 0; b < 4; b++) cnt += int'(rq[b]);
      ov = (cnt >= 2) ? rq : 4'b0;
      if (sof) begin fc_m[i] = cm_m[i]; cm_m[i] = ov; end
      else cm_m[i] = cm_m[i] | ov;
      if (!rot) ptr_m[i] = 0;
      else if (sof) ptr_m[i] = (ptr_m[i] + 1) % n;
    end
  endtask

  task automatic check_all();
    chk("u4.req", 32'(r4), 32'(e_req[0]));
    chk("u4.rgb", 32'(c4), 32'(e_rgb[0]));
    chk("u4.win", 32'(w4), 32'(e_win[0]));
    chk("u4.cmask", 32'(cm4), 32'(cm_m[0]));
    chk("u4.fcoll", 32'(fc4), 32'(fc_m[0]));
    chk("u3.req", 32'(r3), 32'(e_req[1]));
    chk("u3.rgb", 32'(c3), 32'(e_rgb[1]));
    chk("u3.win", 32'(w3), 32'(e_win[1]));
    chk("u3.cmask", 32'(cm3), 32'(cm_m[1][2:0]));
    chk("u3.fcoll", 32'(fc3), 32'(fc_m[1][2:0]));
    chk("u1.req", 32'(r1), 32'(e_req[2]));
    chk("u1.rgb", 32'(c1), 32'(e_rgb[2]));
    chk("u1.win", 32'(w1), 32'(e_win[2]));
    chk("u1.cmask", 32'(cm1), 32'(cm_m[2][0:0]));
    chk("u1.fcoll", 32'(fc1), 32'(fc_m[2][0:0]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rand_rgb();
    for (int i = 0; i < 4; i++) rgb4[i] = 8'($urandom);
  endtask

  int exp_rot [4] = '{3, 3, 3, 0};
  int exp_wrap3 [6] = '{1, 2, 0, 1, 2, 0};

  initial begin
    reset = 1'b1; sof = 1'b0; rot = 1'b0; req4 = '0; rgb4 = '0;
    model_reset();

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      req4 = 4'($urandom); sof = 1'($urandom); rot = 1'($urandom); rand_rgb();
      tick();
    end
    chk("reset.rgb", 32'(c4), 32'hFF);
    chk("reset.cmask", 32'(cm4), 32'h0);

    reset = 1'b0; sof = 1'b0; rot = 1'b0; req4 = '0; rand_rgb();
    tick();
    chk("idle.rgb", 32'(c4), 32'hFF);

    // fixed priority
    rgb4[1] = 8'h1C; rgb4[2] = 8'hE0; req4 = 4'b0110;
    tick();
    chk("fixed.rgb", 32'(c4), 32'h1C);
    chk("fixed.win", 32'(w4), 32'h1);
    chk("fixed.req", 32'(r4), 32'h1);
    req4 = 4'b0000;
    tick();
    chk("drop.rgb", 32'(c4), 32'hFF);
    chk("drop.req", 32'(r4), 32'h0);

    // rotation: winner 0, then 3,3,3,0 after each pulse
    rot = 1'b1; req4 = 4'b1001; rand_rgb();
    tick();
    chk("rot.win0", 32'(w4), 32'h0);
    for (int p = 0; p < 4; p++) begin
      sof = 1'b1;
      tick();
      sof = 1'b0;
      tick();
      chk($sformatf("rot.win%0d", p + 1), 32'(w4), 32'(exp_rot[p]));
    end

    // rotateEn falling returns ptr to 0; then wrap check on the 3-channel build
    rot = 1'b0;
    tick();
    rot = 1'b1; req4 = 4'b0111;
    for (int p = 0; p < 6; p++) begin
      sof = 1'b1;
      tick();
      sof = 1'b0;
      tick();
      chk($sformatf("wrap3.win%0d", p), 32'(w3), 32'(exp_wrap3[p]));
    end
    rot = 1'b0;
    tick();

    // collision accumulation across one frame
    sof = 1'b1; req4 = '0;
    tick();
    sof = 1'b0; req4 = 4'b0011;
    tick();
    tick();
    req4 = 4'b1100;
    tick();
    req4 = 4'b0000;
    tick();
    chk("coll.cmask", 32'(cm4), 32'hF);
    chk("coll.u1cmask", 32'(cm1), 32'h0);
    sof = 1'b1;
    tick();
    chk("coll.fcoll", 32'(fc4), 32'hF);
    chk("coll.cleared", 32'(cm4), 32'h0);

    // overlap on the startOfFrame cycle itself
    sof = 1'b0; req4 = 4'b0011;
    tick();
    sof = 1'b1; req4 = 4'b0101;
    tick();
    chk("sofov.fcoll", 32'(fc4), 32'h3);
    chk("sofov.cmask", 32'(cm4), 32'h5);
    sof = 1'b0;

    // asynchronous reset mid-frame
    req4 = 4'b1110; rot = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async.req", 32'(r4), 32'h0);
    chk("async.rgb", 32'(c4), 32'hFF);
    chk("async.cmask", 32'(cm4), 32'h0);
    chk("async.fcoll", 32'(fc4), 32'h0);
    tick();
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      req4 = 4'($urandom);
      rand_rgb();
      sof = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 40) == 0) rot = ~rot;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_layer_mux.md
Name: sprite_layer_mux

Overview:
- N-channel sprite compositor for the VGA object path; merges per-object drawing requests and 8-bit RGB into one layer request/RGB pair for the top-level priority mux.
- Output is registered, with request and RGB aligned on the same cycle.
- Priority is either fixed or rotating per frame, selected at run time; rotation spreads overdraw flicker across sprites.
- Detects sprite overlaps per frame and reports sticky collision masks for game logic.

Parameters:
- NUM_CH, 4, number of input channels (1..16).
- RGB_W, 8, colour width per channel.
- BG_RGB, 8'hFF, value driven on layerRGB when no channel requests.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- rotateEn  in  1  0 = fixed priority (ch0 highest); 1 = rotating priority.
- drawReq  in  NUM_CH  per-channel drawing request.
- rgbIn  in  NUM_CH x RGB_W  per-channel colour.
- layerDrawingRequest  out  1  registered OR of drawReq.
- layerRGB  out  RGB_W  registered colour of the winning channel, or BG_RGB.
- winnerIdx  out  IDXW  registered index of the winner (IDXW = max(1, clog2(NUM_CH))); 0 when idle.
- collisionMask  out  NUM_CH  sticky: channels that overlapped another channel in the current frame.
- frameCollision  out  NUM_CH  previous frame's collisionMask, captured at startOfFrame.

Behaviour:
- Reset values:
  - layerDrawingRequest = 0, layerRGB = BG_RGB, winnerIdx = 0.
  - ptr = 0, collisionMask = 0, frameCollision = 0.
  - Reset asserted mid-frame clears everything immediately; no partial state survives.
- Latency: exactly 1 clk from drawReq/rgbIn to layerDrawingRequest/layerRGB/winnerIdx. All three update on the same edge.
- Winner selection (combinational, then registered):
  - Scan channels starting at ptr, ascending, modulo NUM_CH.
  - The first channel with drawReq = 1 wins.
  - If no channel requests: layerRGB <= BG_RGB, winnerIdx <= 0, layerDrawingRequest <= 0.
- Priority pointer ptr (IDXW bits):
  - rotateEn = 0: ptr held at 0.
  - rotateEn = 1 and startOfFrame: ptr <= (ptr == NUM_CH-1) ? 0 : ptr+1. Wraps from NUM_CH-1 to 0; NUM_CH need not be a power of 2.
  - The new ptr takes effect from the cycle after the startOfFrame pulse. The startOfFrame cycle itself uses the old ptr.
  - rotateEn falling: ptr <= 0 on the next clk.
  - rotateEn rising: rotation resumes from 0.
- Collision:
  - overlap = drawReq when popcount(drawReq) >= 2, else 0.
  - Each clk: collisionMask <= collisionMask | overlap.
  - On startOfFrame:
    - frameCollision <= collisionMask (old value, excluding the current cycle).
    - collisionMask <= overlap (the current cycle belongs to the new frame).
- NUM_CH = 1: overlap is never set and ptr is constant 0; the block reduces to a registered pass-through with BG fill.
- No back-pressure; the block accepts input every cycle.

Decomposition:
- Shared package vga_pkg holds:
  - RGB_W default constant.
  - BG_WHITE = 8'hFF constant.
  - typedef rgb_t, logic [RGB_W-1:0].
- Sub-module rr_priority_pick: purely combinational rotating priority encoder.
  - Inputs: req[NUM_CH], ptr.
  - Outputs: valid, idx.
  - Reused by the future text/score layer mux.
- Everything else (ptr, output registers, collision logic) stays in sprite_layer_mux.

Test Plan:
- Reset: reset=1 for 3 clk with random inputs -> layerRGB=8'hFF, layerDrawingRequest=0, winnerIdx=0, both masks 0; after release, idle inputs keep layerRGB=8'hFF.
- Fixed priority: rotateEn=0, drawReq=4'b0110, rgbIn[1]=8'h1C, rgbIn[2]=8'hE0 -> one clk later layerRGB=8'h1C, winnerIdx=1, layerDrawingRequest=1; drawReq drops to 0 -> next clk layerRGB=8'hFF, request 0.
- Rotation: rotateEn=1, drawReq=4'b1001 held, 4 startOfFrame pulses -> winnerIdx sequence 0,3,3,3,0 (ptr 0->1->2->3->0); the pulse cycle itself still uses the old ptr.
- Collision: frame with drawReq=4'b0011 for 2 cycles, then 4'b1100 once -> collisionMask=4'b1111; next startOfFrame -> frameCollision=4'b1111, collisionMask=0.
- Simultaneous startOfFrame with overlap drawReq=4'b0101 -> frameCollision=old mask, collisionMask=4'b0101.
- NUM_CH=3 build, rotateEn=1 -> ptr wraps 2->0, never reaches 3; NUM_CH=1 build -> collisionMask stays 0.
